// File: rtl/dlx_pkg.sv
// Shared DLX encodings, ALU operation set and the ALU datapath helper.
package dlx_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_MULT  = 6'h01;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQZ  = 6'h04;
    localparam logic [5:0] OP_BNEZ  = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDUI = 6'h09;
    localparam logic [5:0] OP_SUBI  = 6'h0A;
    localparam logic [5:0] OP_SUBUI = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LHI   = 6'h0F;
    localparam logic [5:0] OP_TRAP  = 6'h11;
    localparam logic [5:0] OP_JR    = 6'h12;
    localparam logic [5:0] OP_JALR  = 6'h13;
    localparam logic [5:0] OP_SLLI  = 6'h14;
    localparam logic [5:0] OP_SRLI  = 6'h16;
    localparam logic [5:0] OP_SRAI  = 6'h17;
    localparam logic [5:0] OP_SEQI  = 6'h18;
    localparam logic [5:0] OP_SNEI  = 6'h19;
    localparam logic [5:0] OP_SLTI  = 6'h1A;
    localparam logic [5:0] OP_SGTI  = 6'h1B;
    localparam logic [5:0] OP_SLEI  = 6'h1C;
    localparam logic [5:0] OP_SGEI  = 6'h1D;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL   = 6'h04;
    localparam logic [5:0] F_SRL   = 6'h06;
    localparam logic [5:0] F_SRA   = 6'h07;
    localparam logic [5:0] F_MULT  = 6'h0E;
    localparam logic [5:0] F_MULTU = 6'h16;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_SEQ   = 6'h28;
    localparam logic [5:0] F_SNE   = 6'h29;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_SGT   = 6'h2B;
    localparam logic [5:0] F_SLE   = 6'h2C;
    localparam logic [5:0] F_SGE   = 6'h2D;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SEQ, ALU_SNE,
        ALU_SLT, ALU_SGT, ALU_SLE, ALU_SGE, ALU_LHI
    } alu_op_e;

    typedef enum logic [1:0] {MEM_B, MEM_H, MEM_W} mem_size_e;
    typedef enum logic [1:0] {WB_ALU, WB_MULT, WB_LOAD, WB_LINK} wb_sel_e;
    typedef enum logic [1:0] {PC_SEQ, PC_BR, PC_JMP, PC_REG} pc_sel_e;

    // Set opcodes 18..1D and set funcs 28..2D share their low three bits.
    function automatic alu_op_e set_op(input logic [2:0] k);
        case (k)
            3'd0:    return ALU_SEQ;
            3'd1:    return ALU_SNE;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SGT;
            3'd4:    return ALU_SLE;
            default: return ALU_SGE;
        endcase
    endfunction

    function automatic logic [31:0] alu(input alu_op_e op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
        case (op)
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_XOR: return a ^ b;
            ALU_SLL: return a << b[4:0];
            ALU_SRL: return a >> b[4:0];
            ALU_SRA: return $signed(a) >>> b[4:0];
            ALU_SEQ: return {31'd0, a == b};
            ALU_SNE: return {31'd0, a != b};
            ALU_SLT: return {31'd0, $signed(a) < $signed(b)};
            ALU_SGT: return {31'd0, $signed(a) > $signed(b)};
            ALU_SLE: return {31'd0, $signed(a) <= $signed(b)};
            ALU_SGE: return {31'd0, $signed(a) >= $signed(b)};
            ALU_LHI: return {b[15:0], 16'd0};
            default: return a + b;
        endcase
    endfunction

endpackage

// File: rtl/dlx_dmem.sv
// Big-endian byte-addressed data memory: combinational word read, B/H/W write.
module dlx_dmem
    import dlx_pkg::*;
#(
    parameter int SIZE = 32768,
    localparam int AW = $clog2(SIZE)
) (
    input  logic          clk,
    input  logic          we,
    input  mem_size_e     size,
    input  logic [AW-1:0] addr,
    input  logic [0:31]   wdata,
    output logic [0:31]   rdata
);
    logic [7:0] mem [0:SIZE-1];
    logic [AW-1:0] a1, a2, a3;

    assign a1 = addr + AW'(1);
    assign a2 = addr + AW'(2);
    assign a3 = addr + AW'(3);
    assign rdata = {mem[addr], mem[a1], mem[a2], mem[a3]};

    always_ff @(posedge clk) begin
        if (we) begin
            case (size)
                MEM_B: mem[addr] <= wdata[24:31];
                MEM_H: begin
                    mem[addr] <= wdata[16:23];
                    mem[a1]   <= wdata[24:31];
                end
                default: begin
                    mem[addr] <= wdata[0:7];
                    mem[a1]   <= wdata[8:15];
                    mem[a2]   <= wdata[16:23];
                    mem[a3]   <= wdata[24:31];
                end
            endcase
        end
    end
endmodule

// File: rtl/dlx_imem.sv
// Big-endian byte-addressed instruction memory with combinational word fetch.
module dlx_imem #(
    parameter int SIZE = 32768,
    localparam int AW = $clog2(SIZE)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [0:31]   wdata,
    input  logic [AW-1:0] addr,
    output logic [0:31]   rdata
);
    logic [7:0] mem [0:SIZE-1];
    logic [AW-1:0] a1, a2, a3;

    assign a1 = addr + AW'(1);
    assign a2 = addr + AW'(2);
    assign a3 = addr + AW'(3);
    assign rdata = {mem[addr], mem[a1], mem[a2], mem[a3]};

    // Load port kept for future bootloading; the core ties it off.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr]          <= wdata[0:7];
            mem[waddr + AW'(1)] <= wdata[8:15];
            mem[waddr + AW'(2)] <= wdata[16:23];
            mem[waddr + AW'(3)] <= wdata[24:31];
        end
    end
endmodule

// File: rtl/dlx_regfile.sv
// 32 x 32 register file, two combinational reads, r0 hardwired to zero.
module dlx_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [0:31] wdata,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [0:31] rd1,
    output logic [0:31] rd2
);
    logic [0:31] reg_out [0:31];

    assign rd1 = (ra1 == 5'd0) ? 32'd0 : reg_out[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'd0 : reg_out[ra2];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) reg_out[i] <= 32'd0;
        end else if (we && waddr != 5'd0) begin
            reg_out[waddr] <= wdata;
        end
    end
endmodule

// File: rtl/single_cycle_cpu.sv
// Single-cycle DLX core: fetch, decode, execute and retire in one clock.
module single_cycle_cpu
    import dlx_pkg::*;
#(
    parameter int IMEM_SIZE = 32768,
    parameter int DMEM_SIZE = 32768
) (
    input  logic        clock,
    input  logic        reset,
    output logic [0:31] busWout,
    output logic [0:31] instructionOut
);
    localparam int IAW = $clog2(IMEM_SIZE);
    localparam int DAW = $clog2(DMEM_SIZE);

    logic [0:31] instruction, instructionAddr, pc4;
    logic [0:15] imm16;
    logic [0:31] imm_ext, off_ext, rs1v, rs2v;
    logic [0:31] aluOut, mult, aluOrMultOut, dword, loadv, busW;
    logic [5:0]  op, func;
    logic [4:0]  dst;
    alu_op_e     alu_op;
    mem_size_e   msize;
    wb_sel_e     wb_sel;
    pc_sel_e     pc_sel;
    logic        use_imm, imm_zext, reg_we, mem_we, lsext, halt;

    dlx_imem #(.SIZE(IMEM_SIZE)) I_MEM (
        .clk(clock), .we(1'b0), .waddr('0), .wdata('0),
        .addr(instructionAddr[32-IAW:31]), .rdata(instruction)
    );

    assign op    = instruction[0:5];
    assign func  = instruction[26:31];
    assign imm16 = instruction[16:31];
    assign pc4   = instructionAddr + 32'd4;
    assign imm_ext = imm_zext ? {16'd0, imm16} : {{16{imm16[0]}}, imm16};
    assign off_ext = {{6{instruction[6]}}, instruction[6:31]};

    dlx_regfile REGFILE (
        .clk(clock), .reset(reset), .we(reg_we & ~halt),
        .waddr(dst), .wdata(busW),
        .ra1(instruction[6:10]), .ra2(instruction[11:15]),
        .rd1(rs1v), .rd2(rs2v)
    );

    always_comb begin
        alu_op = ALU_ADD; use_imm = 1'b1; imm_zext = 1'b0;
        reg_we = 1'b0; dst = instruction[11:15]; wb_sel = WB_ALU;
        mem_we = 1'b0; msize = MEM_W; lsext = 1'b1;
        pc_sel = PC_SEQ; halt = 1'b0;
        case (op)
            OP_RTYPE: begin
                use_imm = 1'b0; dst = instruction[16:20]; reg_we = 1'b1;
                case (func)
                    F_SLL: alu_op = ALU_SLL;
                    F_SRL: alu_op = ALU_SRL;
                    F_SRA: alu_op = ALU_SRA;
                    F_ADD, F_ADDU: alu_op = ALU_ADD;
                    F_SUB, F_SUBU: alu_op = ALU_SUB;
                    F_AND: alu_op = ALU_AND;
                    F_OR:  alu_op = ALU_OR;
                    F_XOR: alu_op = ALU_XOR;
                    F_SEQ, F_SNE, F_SLT, F_SGT, F_SLE, F_SGE:
                        alu_op = set_op(func[2:0]);
                    default: reg_we = 1'b0;
                endcase
            end
            OP_MULT: begin
                use_imm = 1'b0; dst = instruction[16:20]; wb_sel = WB_MULT;
                reg_we = (func == F_MULT) || (func == F_MULTU);
            end
            OP_J: pc_sel = PC_JMP;
            OP_JAL: begin
                pc_sel = PC_JMP; reg_we = 1'b1; dst = 5'd31; wb_sel = WB_LINK;
            end
            OP_BEQZ: if (rs1v == 32'd0) pc_sel = PC_BR;
            OP_BNEZ: if (rs1v != 32'd0) pc_sel = PC_BR;
            OP_JR: pc_sel = PC_REG;
            OP_JALR: begin
                pc_sel = PC_REG; reg_we = 1'b1; dst = 5'd31; wb_sel = WB_LINK;
            end
            OP_TRAP: halt = 1'b1;
            OP_ADDI, OP_ADDUI: reg_we = 1'b1;
            OP_SUBI, OP_SUBUI: begin reg_we = 1'b1; alu_op = ALU_SUB; end
            OP_ANDI: begin reg_we = 1'b1; imm_zext = 1'b1; alu_op = ALU_AND; end
            OP_ORI:  begin reg_we = 1'b1; imm_zext = 1'b1; alu_op = ALU_OR;  end
            OP_XORI: begin reg_we = 1'b1; imm_zext = 1'b1; alu_op = ALU_XOR; end
            OP_LHI:  begin reg_we = 1'b1; imm_zext = 1'b1; alu_op = ALU_LHI; end
            OP_SLLI: begin reg_we = 1'b1; imm_zext = 1'b1; alu_op = ALU_SLL; end
            OP_SRLI: begin reg_we = 1'b1; imm_zext = 1'b1; alu_op = ALU_SRL; end
            OP_SRAI: begin reg_we = 1'b1; imm_zext = 1'b1; alu_op = ALU_SRA; end
            OP_SEQI, OP_SNEI, OP_SLTI, OP_SGTI, OP_SLEI, OP_SGEI: begin
                reg_we = 1'b1; alu_op = set_op(op[2:0]);
            end
            OP_LB:  begin reg_we = 1'b1; wb_sel = WB_LOAD; msize = MEM_B; end
            OP_LH:  begin reg_we = 1'b1; wb_sel = WB_LOAD; msize = MEM_H; end
            OP_LW:  begin reg_we = 1'b1; wb_sel = WB_LOAD; end
            OP_LBU: begin
                reg_we = 1'b1; wb_sel = WB_LOAD; msize = MEM_B; lsext = 1'b0;
            end
            OP_LHU: begin
                reg_we = 1'b1; wb_sel = WB_LOAD; msize = MEM_H; lsext = 1'b0;
            end
            OP_SB: begin mem_we = 1'b1; msize = MEM_B; end
            OP_SH: begin mem_we = 1'b1; msize = MEM_H; end
            OP_SW: mem_we = 1'b1;
            default: ;
        endcase
    end

    assign aluOut = alu(alu_op, rs1v, use_imm ? imm_ext : rs2v);
    assign mult   = rs1v * rs2v;
    assign aluOrMultOut = (wb_sel == WB_MULT) ? mult : aluOut;

    dlx_dmem #(.SIZE(DMEM_SIZE)) DATA_MEM (
        .clk(clock), .we(mem_we & ~reset), .size(msize),
        .addr(aluOut[32-DAW:31]), .wdata(rs2v), .rdata(dword)
    );

    // The word read starts at the load address, so B/H live in its top bytes.
    always_comb begin
        case (msize)
            MEM_B:   loadv = {{24{lsext & dword[0]}}, dword[0:7]};
            MEM_H:   loadv = {{16{lsext & dword[0]}}, dword[0:15]};
            default: loadv = dword;
        endcase
    end

    always_comb begin
        case (wb_sel)
            WB_LOAD: busW = loadv;
            WB_LINK: busW = pc4;
            default: busW = aluOrMultOut;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            instructionAddr <= 32'd0;
        end else if (!halt) begin
            case (pc_sel)
                PC_BR:   instructionAddr <= pc4 + imm_ext;
                PC_JMP:  instructionAddr <= pc4 + off_ext;
                PC_REG:  instructionAddr <= rs1v;
                default: instructionAddr <= pc4;
            endcase
        end
    end

    assign busWout        = busW;
    assign instructionOut = instruction;
endmodule

// File: tb/tb_single_cycle_cpu.sv
// Directed program bench for single_cycle_cpu with backdoor memory preload.
module tb_single_cycle_cpu;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [0:31] busWout, instructionOut;
    int checks = 0;
    int errors = 0;

    single_cycle_cpu dut (
        .clock(clock), .reset(reset),
        .busWout(busWout), .instructionOut(instructionOut)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic put_word(input int a, input logic [31:0] w);
        dut.I_MEM.mem[a]   <= w[31:24];
        dut.I_MEM.mem[a+1] <= w[23:16];
        dut.I_MEM.mem[a+2] <= w[15:8];
        dut.I_MEM.mem[a+3] <= w[7:0];
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_regs_zero(input string tag);
        for (int i = 0; i < 32; i++)
            check($sformatf("%s r%0d", tag, i), dut.REGFILE.reg_out[i], 32'd0);
    endtask

    initial begin
        put_word(32'h00, 32'h20010005);
        put_word(32'h04, 32'h00211020);
        put_word(32'h08, 32'hAC020000);
        put_word(32'h0C, 32'h8C030000);
        put_word(32'h10, 32'h0C00002C);
        put_word(32'h14, 32'h80040004);
        put_word(32'h18, 32'h90050004);
        put_word(32'h1C, 32'h20060007);
        put_word(32'h20, 32'h2007FFFD);
        put_word(32'h24, 32'h04C7400E);
        put_word(32'h28, 32'h14200008);
        put_word(32'h2C, 32'h200A0001);
        put_word(32'h30, 32'h200A0001);
        put_word(32'h34, 32'h10200008);
        put_word(32'h38, 32'h00224822);
        put_word(32'h3C, 32'h44000300);
        put_word(32'h40, 32'h4BE00000);
        for (int i = 0; i < 8; i++) dut.DATA_MEM.mem[i] <= 8'h00;
        dut.DATA_MEM.mem[4] <= 8'h80;

        tick();
        check("reset pc", dut.instructionAddr, 32'h0);
        check("reset instr", instructionOut, 32'h20010005);
        check_regs_zero("reset");
        reset = 1'b0;
        #1;

        check("addi busw", busWout, 32'h5);
        tick();
        check("addi r1", dut.REGFILE.reg_out[1], 32'h5);
        check("add busw", busWout, 32'hA);
        tick();
        check("add r2", dut.REGFILE.reg_out[2], 32'hA);
        check("sw instr", instructionOut, 32'hAC020000);
        tick();
        check("sw m0", {24'd0, dut.DATA_MEM.mem[0]}, 32'h00);
        check("sw m1", {24'd0, dut.DATA_MEM.mem[1]}, 32'h00);
        check("sw m2", {24'd0, dut.DATA_MEM.mem[2]}, 32'h00);
        check("sw m3", {24'd0, dut.DATA_MEM.mem[3]}, 32'h0A);
        check("lw busw", busWout, 32'hA);
        tick();
        check("lw r3", dut.REGFILE.reg_out[3], 32'hA);
        check("jal pc", dut.instructionAddr, 32'h10);
        check("jal busw", busWout, 32'h14);
        tick();
        check("jal r31", dut.REGFILE.reg_out[31], 32'h14);
        check("jal target", dut.instructionAddr, 32'h40);
        tick();
        check("jr target", dut.instructionAddr, 32'h14);
        check("lb busw", busWout, 32'hFFFFFF80);
        tick();
        check("lbu busw", busWout, 32'h00000080);
        tick();
        check("lb r4", dut.REGFILE.reg_out[4], 32'hFFFFFF80);
        check("lbu r5", dut.REGFILE.reg_out[5], 32'h00000080);
        check("addi7 busw", busWout, 32'h7);
        tick();
        check("addi-3 busw", busWout, 32'hFFFFFFFD);
        tick();
        check("mult busw", busWout, 32'hFFFFFFEB);
        tick();
        check("mult r8", dut.REGFILE.reg_out[8], 32'hFFFFFFEB);
        check("bnez pc", dut.instructionAddr, 32'h28);
        tick();
        check("bnez taken", dut.instructionAddr, 32'h34);
        tick();
        check("beqz fallthru", dut.instructionAddr, 32'h38);
        check("sub busw", busWout, 32'hFFFFFFFB);
        tick();
        check("sub r9", dut.REGFILE.reg_out[9], 32'hFFFFFFFB);
        check("trap instr", instructionOut, 32'h44000300);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("trap pc", dut.instructionAddr, 32'h3C);
            check("trap r9", dut.REGFILE.reg_out[9], 32'hFFFFFFFB);
            check("trap r31", dut.REGFILE.reg_out[31], 32'h14);
            check("skipped r10", dut.REGFILE.reg_out[10], 32'h0);
            check("trap m3", {24'd0, dut.DATA_MEM.mem[3]}, 32'h0A);
        end

        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("rerst pc", dut.instructionAddr, 32'h0);
        check("rerst instr", instructionOut, 32'h20010005);
        check_regs_zero("rerst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
